// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcode/funct encodings, ALU select codes,
// immediate-extension type and the decoded-control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_NOT = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_DEC = 4'd4;
  localparam logic [3:0] ALU_ADD = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_INC = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;

  typedef enum logic {
    EXT_SIGN = 1'b0,
    EXT_ZERO = 1'b1
  } ext_e;

  typedef enum logic {
    DEST_RT = 1'b0,
    DEST_RD = 1'b1
  } dest_sel_e;

  typedef struct packed {
    logic [3:0] sel;
    logic       b_is_imm;
    ext_e       ext;
    dest_sel_e  dest_sel;
    logic       we;
    logic       is_load;
    logic       is_store;
    logic       is_beq;
    logic       is_bne;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct decoder producing ALU select, operand-B source,
// immediate extension, destination select, write enable and class flags.
module alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  dec_t dec;

  always_comb begin
    dec          = '0;
    dec.sel      = ALU_ADD;
    dec.ext      = EXT_SIGN;
    dec.dest_sel = DEST_RT;
    unique case (opcode_i)
      OP_RTYPE: begin
        dec.dest_sel = DEST_RD;
        dec.we       = 1'b1;
        unique case (funct_i)
          FN_ADD, FN_ADDU: dec.sel = ALU_ADD;
          FN_SUB, FN_SUBU: dec.sel = ALU_SUB;
          FN_AND:          dec.sel = ALU_AND;
          FN_OR:           dec.sel = ALU_OR;
          FN_XOR:          dec.sel = ALU_XOR;
          FN_SLT:          dec.sel = ALU_SLT;
          default: begin
            dec.we      = 1'b0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec.sel      = ALU_ADD;
        dec.b_is_imm = 1'b1;
        dec.we       = 1'b1;
      end
      OP_SLTI: begin
        dec.sel      = ALU_SLT;
        dec.b_is_imm = 1'b1;
        dec.we       = 1'b1;
      end
      OP_ANDI: begin
        dec.sel      = ALU_AND;
        dec.b_is_imm = 1'b1;
        dec.ext      = EXT_ZERO;
        dec.we       = 1'b1;
      end
      OP_ORI: begin
        dec.sel      = ALU_OR;
        dec.b_is_imm = 1'b1;
        dec.ext      = EXT_ZERO;
        dec.we       = 1'b1;
      end
      OP_XORI: begin
        dec.sel      = ALU_XOR;
        dec.b_is_imm = 1'b1;
        dec.ext      = EXT_ZERO;
        dec.we       = 1'b1;
      end
      OP_LW: begin
        dec.sel      = ALU_ADD;
        dec.b_is_imm = 1'b1;
        dec.we       = 1'b1;
        dec.is_load  = 1'b1;
      end
      OP_SW: begin
        dec.sel      = ALU_ADD;
        dec.b_is_imm = 1'b1;
        dec.is_store = 1'b1;
      end
      OP_BEQ: begin
        dec.sel    = ALU_SUB;
        dec.is_beq = 1'b1;
      end
      OP_BNE: begin
        dec.sel    = ALU_SUB;
        dec.is_bne = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign dec_o = dec;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes into ALU controls, registers operands and
// forwards EX/MEM and MEM/WB results onto the ALU inputs during EX.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic          stall,
  input  logic          flush,
  input  logic          exmem_we,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_we,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_sel,
  output logic [DW-1:0] store_data,
  output logic          ex_valid,
  output logic [RW-1:0] ex_dest,
  output logic          ex_dest_we,
  output logic          ex_is_load,
  output logic          ex_is_store,
  output logic          ex_is_beq,
  output logic          ex_is_bne,
  output logic          ex_illegal
);

  typedef struct packed {
    logic          valid;
    logic [3:0]    sel;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          b_is_imm;
    logic [RW-1:0] dest;
    logic          we;
    logic          is_load;
    logic          is_store;
    logic          is_beq;
    logic          is_bne;
    logic          illegal;
  } ex_t;

  // Bubble zeroes rs/rt too, so a bubble can never match a forward source.
  function automatic ex_t bubble_f();
    ex_t b;
    b     = '0;
    b.sel = ALU_ADD;
    return b;
  endfunction

  dec_t          dec;
  ex_t           load_c;
  ex_t           ex_d;
  ex_t           ex_q;
  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;
  logic [RW-1:0] dest_c;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  alu_decode u_alu_decode (
    .opcode_i (id_opcode),
    .funct_i  (id_funct),
    .dec_o    (dec)
  );

  assign imm_sext = {{(DW-16){id_imm[15]}}, id_imm};
  assign imm_zext = {{(DW-16){1'b0}}, id_imm};
  assign dest_c   = (dec.dest_sel == DEST_RD) ? id_rd : id_rt;

  always_comb begin
    load_c          = '0;
    load_c.valid    = 1'b1;
    load_c.sel      = dec.sel;
    load_c.rs       = id_rs;
    load_c.rt       = id_rt;
    load_c.rs_data  = id_rs_data;
    load_c.rt_data  = id_rt_data;
    load_c.imm      = (dec.ext == EXT_ZERO) ? imm_zext : imm_sext;
    load_c.b_is_imm = dec.b_is_imm;
    load_c.dest     = dest_c;
    load_c.we       = dec.we && (dest_c != '0);
    load_c.is_load  = dec.is_load;
    load_c.is_store = dec.is_store;
    load_c.is_beq   = dec.is_beq;
    load_c.is_bne   = dec.is_bne;
    load_c.illegal  = dec.illegal;
  end

  // Flush beats stall; an empty decode slot only bubbles when not stalled.
  always_comb begin
    ex_d = load_c;
    if (flush) begin
      ex_d = bubble_f();
    end else if (stall) begin
      ex_d = ex_q;
    end else if (!id_valid) begin
      ex_d = bubble_f();
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= bubble_f();
    end else begin
      ex_q <= ex_d;
    end
  end

  // Youngest producer (EX/MEM) wins; register 0 is never forwarded.
  always_comb begin
    fwd_a = ex_q.rs_data;
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == ex_q.rs)) begin
      fwd_a = exmem_data;
    end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == ex_q.rs)) begin
      fwd_a = memwb_data;
    end
  end

  always_comb begin
    fwd_b = ex_q.rt_data;
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == ex_q.rt)) begin
      fwd_b = exmem_data;
    end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == ex_q.rt)) begin
      fwd_b = memwb_data;
    end
  end

  assign alu_a       = fwd_a;
  assign alu_b       = ex_q.b_is_imm ? ex_q.imm : fwd_b;
  assign store_data  = fwd_b;
  assign alu_sel     = ex_q.sel;
  assign ex_valid    = ex_q.valid;
  assign ex_dest     = ex_q.dest;
  assign ex_dest_we  = ex_q.we;
  assign ex_is_load  = ex_q.is_load;
  assign ex_is_store = ex_q.is_store;
  assign ex_is_beq   = ex_q.is_beq;
  assign ex_is_bne   = ex_q.is_bne;
  assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes expected EX outputs into a
// queue, a negedge monitor pops and compares against the DUT.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  sel;
    logic        valid;
    logic [4:0]  dest;
    logic        we;
    logic        ld;
    logic        st;
    logic        beq;
    logic        bne;
    logic        ill;
  } obs_t;

  localparam int EW = $bits(obs_t);

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [15:0] id_imm;
  logic        stall;
  logic        flush;
  logic        exmem_we;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_data;
  logic        memwb_we;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] store_data;
  logic        ex_valid;
  logic [4:0]  ex_dest;
  logic        ex_dest_we;
  logic        ex_is_load;
  logic        ex_is_store;
  logic        ex_is_beq;
  logic        ex_is_bne;
  logic        ex_illegal;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks;
  int            failures;

  id_ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_funct    (id_funct),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_rs_data  (id_rs_data),
    .id_rt_data  (id_rt_data),
    .id_imm      (id_imm),
    .stall       (stall),
    .flush       (flush),
    .exmem_we    (exmem_we),
    .exmem_rd    (exmem_rd),
    .exmem_data  (exmem_data),
    .memwb_we    (memwb_we),
    .memwb_rd    (memwb_rd),
    .memwb_data  (memwb_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .store_data  (store_data),
    .ex_valid    (ex_valid),
    .ex_dest     (ex_dest),
    .ex_dest_we  (ex_dest_we),
    .ex_is_load  (ex_is_load),
    .ex_is_store (ex_is_store),
    .ex_is_beq   (ex_is_beq),
    .ex_is_bne   (ex_is_bne),
    .ex_illegal  (ex_illegal)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] sd, input logic [3:0] sel,
                              input logic valid, input logic [4:0] dest,
                              input logic we, input logic ld, input logic st,
                              input logic beq, input logic bne, input logic ill);
    obs_t o;
    o.a = a; o.b = b; o.sd = sd; o.sel = sel; o.valid = valid; o.dest = dest;
    o.we = we; o.ld = ld; o.st = st; o.beq = beq; o.bne = bne; o.ill = ill;
    return o;
  endfunction

  function automatic obs_t bubble_exp();
    return mk(32'h0, 32'h0, 32'h0, 4'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic [31:0] rsd, input logic [31:0] rtd);
    id_valid   = 1'b1;
    id_opcode  = op;
    id_funct   = fn;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_imm     = imm;
    id_rs_data = rsd;
    id_rt_data = rtd;
  endtask

  task automatic fwd_set(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mr, input logic [31:0] md);
    exmem_we   = ew;
    exmem_rd   = er;
    exmem_data = ed;
    memwb_we   = mw;
    memwb_rd   = mr;
    memwb_data = md;
  endtask

  // Scoreboard monitor
  initial begin
    obs_t e;
    obs_t act;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = mk(alu_a, alu_b, store_data, alu_sel, ex_valid, ex_dest, ex_dest_we,
                 ex_is_load, ex_is_store, ex_is_beq, ex_is_bne, ex_illegal);
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got a=%h b=%h sd=%h sel=%0d v=%b dest=%0d we=%b ld=%b st=%b beq=%b bne=%b ill=%b; want a=%h b=%h sd=%h sel=%0d v=%b dest=%0d we=%b ld=%b st=%b beq=%b bne=%b ill=%b",
                   nm, act.a, act.b, act.sd, act.sel, act.valid, act.dest, act.we,
                   act.ld, act.st, act.beq, act.bne, act.ill,
                   e.a, e.b, e.sd, e.sel, e.valid, e.dest, e.we,
                   e.ld, e.st, e.beq, e.bne, e.ill);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: stimulus did not complete within 100000 time units");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Stimulus
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    drive(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    id_valid = 1'b0;
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    next_cycle();
    push("reset", bubble_exp());
    rst = 1'b0;
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'd5, 32'd7);

    next_cycle();
    push("add", mk(32'd5, 32'd7, 32'd7, 4'd5, 1, 5'd3, 1, 0, 0, 0, 0, 0));
    drive(6'h0A, 6'h00, 5'd1, 5'd6, 5'd0, 16'hFFFF, 32'd5, 32'd9);

    next_cycle();
    push("slti", mk(32'd5, 32'hFFFF_FFFF, 32'd9, 4'd8, 1, 5'd6, 1, 0, 0, 0, 0, 0));
    drive(6'h0D, 6'h00, 5'd1, 5'd7, 5'd0, 16'h8000, 32'h10, 32'h20);

    next_cycle();
    push("ori", mk(32'h10, 32'h0000_8000, 32'h20, 4'd3, 1, 5'd7, 1, 0, 0, 0, 0, 0));
    drive(6'h00, 6'h21, 5'd4, 5'd5, 5'd0, 16'h0, 32'h11, 32'h22);

    next_cycle();
    fwd_set(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
    push("fwd_exmem_prio", mk(32'hAA, 32'h22, 32'h22, 4'd5, 1, 5'd0, 0, 0, 0, 0, 0, 0));
    stall = 1'b1;
    drive(6'h00, 6'h22, 5'd1, 5'd2, 5'd8, 16'h0, 32'd1, 32'd2);

    next_cycle();
    fwd_set(1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
    push("stall_fwd_memwb", mk(32'hBB, 32'h22, 32'h22, 4'd5, 1, 5'd0, 0, 0, 0, 0, 0, 0));
    drive(6'h0E, 6'h00, 5'd3, 5'd3, 5'd0, 16'h1, 32'd3, 32'd3);

    next_cycle();
    fwd_set(1'b1, 5'd5, 32'hCC, 1'b1, 5'd4, 32'hBB);
    push("stall_fwd_rt", mk(32'hBB, 32'hCC, 32'hCC, 4'd5, 1, 5'd0, 0, 0, 0, 0, 0, 0));
    drive(6'h00, 6'h24, 5'd6, 5'd6, 5'd6, 16'h0, 32'd6, 32'd6);

    next_cycle();
    fwd_set(1'b0, 5'd5, 32'hCC, 1'b1, 5'd5, 32'hDD);
    push("stall_fwd_rt_memwb", mk(32'h11, 32'hDD, 32'hDD, 4'd5, 1, 5'd0, 0, 0, 0, 0, 0, 0));
    stall = 1'b0;
    drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd9, 16'h0, 32'h55, 32'h66);

    next_cycle();
    fwd_set(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    push("no_fwd_r0", mk(32'h55, 32'h66, 32'h66, 4'd5, 1, 5'd9, 1, 0, 0, 0, 0, 0));
    flush = 1'b1;
    stall = 1'b1;
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'd5, 32'd7);

    next_cycle();
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    push("flush_stall", bubble_exp());
    flush = 1'b0;
    stall = 1'b0;
    drive(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 16'h10, 32'd3, 32'd3);

    next_cycle();
    push("beq", mk(32'd3, 32'd3, 32'd3, 4'd6, 1, 5'd2, 0, 0, 0, 1, 0, 0));
    drive(6'h2B, 6'h00, 5'd1, 5'd6, 5'd0, 16'hFFFC, 32'h100, 32'h77);

    next_cycle();
    fwd_set(1'b1, 5'd6, 32'h1234, 1'b0, 5'd0, 32'h0);
    push("sw", mk(32'h100, 32'hFFFF_FFFC, 32'h1234, 4'd5, 1, 5'd6, 0, 0, 1, 0, 0, 0));
    drive(6'h23, 6'h00, 5'd2, 5'd3, 5'd0, 16'h4, 32'h200, 32'h9);

    next_cycle();
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    push("lw", mk(32'h200, 32'h4, 32'h9, 4'd5, 1, 5'd3, 1, 1, 0, 0, 0, 0));
    drive(6'h3F, 6'h00, 5'd1, 5'd2, 5'd0, 16'h5, 32'd1, 32'd2);

    next_cycle();
    push("illegal_op", mk(32'd1, 32'd2, 32'd2, 4'd5, 1, 5'd2, 0, 0, 0, 0, 0, 1));
    drive(6'h05, 6'h00, 5'd3, 5'd4, 5'd0, 16'h0, 32'd9, 32'd4);

    next_cycle();
    push("bne", mk(32'd9, 32'd4, 32'd4, 4'd6, 1, 5'd4, 0, 0, 0, 0, 1, 0));
    drive(6'h00, 6'h00, 5'd1, 5'd2, 5'd3, 16'h0, 32'd1, 32'd2);

    next_cycle();
    push("illegal_funct", mk(32'd1, 32'd2, 32'd2, 4'd5, 1, 5'd3, 0, 0, 0, 0, 0, 1));
    drive(6'h0C, 6'h00, 5'd1, 5'd10, 5'd0, 16'hF0F0, 32'h1234, 32'h5);

    next_cycle();
    push("andi", mk(32'h1234, 32'h0000_F0F0, 32'h5, 4'd1, 1, 5'd10, 1, 0, 0, 0, 0, 0));
    id_valid = 1'b0;

    next_cycle();
    push("invalid_bubble", bubble_exp());
    drive(6'h00, 6'h26, 5'd1, 5'd2, 5'd11, 16'h0, 32'hF0, 32'h0F);

    next_cycle();
    push("xor", mk(32'hF0, 32'h0F, 32'h0F, 4'd2, 1, 5'd11, 1, 0, 0, 0, 0, 0));
    drive(6'h00, 6'h25, 5'd1, 5'd2, 5'd12, 16'h0, 32'd1, 32'd2);

    next_cycle();
    rst   = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    fwd_set(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    push("reset_mid_cycle", bubble_exp());

    next_cycle();
    push("reset_held", bubble_exp());
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive(6'h00, 6'h2A, 5'd1, 5'd2, 5'd13, 16'h0, 32'd3, 32'd4);

    next_cycle();
    push("slt_after_reset", mk(32'd3, 32'd4, 32'd4, 4'd8, 1, 5'd13, 1, 0, 0, 0, 0, 0));

    next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It registers decoded operands each cycle and translates opcode/funct into the ALU's 4-bit select code. It also applies immediate extension and EX/MEM and MEM/WB forwarding, so the ALU receives final `alu_a`, `alu_b` and `alu_sel` in the EX cycle. It supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
- `DW`, default 32: datapath width.
- `RW`, default 5: register-address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_opcode` in 6: instruction [31:26].
- `id_funct` in 6: instruction [5:0].
- `id_rs`, `id_rt`, `id_rd` in RW each: register addresses.
- `id_rs_data`, `id_rt_data` in DW each: register-file read data.
- `id_imm` in 16: instruction [15:0].
- `stall` in 1: hold all stage registers.
- `flush` in 1: load a bubble.
- `exmem_we` in 1, `exmem_rd` in RW, `exmem_data` in DW: EX/MEM writeback candidate.
- `memwb_we` in 1, `memwb_rd` in RW, `memwb_data` in DW: MEM/WB writeback candidate.
- `alu_a`, `alu_b` out DW each: forwarded ALU operands.
- `alu_sel` out 4: ALU select code.
- `store_data` out DW: forwarded rt value for `sw`.
- `ex_valid` out 1, `ex_dest` out RW, `ex_dest_we` out 1: destination register and its write enable.
- `ex_is_load`, `ex_is_store`, `ex_is_beq`, `ex_is_bne`, `ex_illegal` out 1 each: instruction class flags.

## Operation
- **ALU select codes:** NOT=0, AND=1, XOR=2, OR=3, DEC=4, ADD=5, SUB=6, INC=7, SLT=8.
- **R-type decode** (opcode 0x00), by funct:
  - 0x20/0x21 → ADD; 0x22/0x23 → SUB.
  - 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x2A → SLT.
  - B comes from rt; dest = rd; we = 1.
- **I-type decode**, by opcode:
  - addi 0x08 / addiu 0x09 → ADD, sign-extended immediate.
  - slti 0x0A → SLT, sign-extended immediate.
  - andi 0x0C → AND; ori 0x0D → OR; xori 0x0E → XOR; all zero-extended immediate.
  - For all of the above: dest = rt; we = 1.
- **Memory decode:**
  - lw 0x23 → ADD, sign-extended immediate; dest = rt; we = 1; is_load = 1.
  - sw 0x2B → ADD, sign-extended immediate; we = 0; is_store = 1.
- **Branch decode:** beq 0x04 / bne 0x05 → SUB, B from rt, we = 0, matching branch flag = 1 (consumer uses `Is0`).
- **Illegal encodings:** any other opcode/funct → ADD, we = 0, all class flags 0, `ex_illegal` = 1.
- **Destination zero:** `ex_dest_we` is forced to 0 when the decoded destination is 0.
- **Registered fields:** valid, sel, rs, rt, rs_data, rt_data, extended immediate, b_is_imm, dest, we and flags are all captured at the ID→EX edge.
- **Forwarding** is combinational on the registered values, applied per operand (rs → A; rt → B and `store_data`):
  - If `exmem_we` and `exmem_rd` ≠ 0 and `exmem_rd` == reg, use `exmem_data`.
  - Else if `memwb_we` and `memwb_rd` ≠ 0 and `memwb_rd` == reg, use `memwb_data`.
  - Else use the registered data.
- **B operand:** `alu_b` = extended immediate when b_is_imm, otherwise the forwarded rt value. `store_data` is always the forwarded rt value.
- **Invalid input:** `id_valid` = 0 loads a bubble, identical to flush.
- **Bubble contents:** valid = 0, sel = ADD, data = 0, we = 0, all flags = 0.
- **Load-use hazards** are not detected here; the hazard unit asserts `stall` upstream.

## Timing
- **Latency:** one cycle from the ID inputs to the registered EX fields. `alu_a`, `alu_b` and `store_data` settle combinationally in the same EX cycle.
- **Reset** (asynchronous, immediate):
  - All registers load the bubble contents.
  - Outputs read `alu_a` = 0, `alu_b` = 0, `store_data` = 0, `alu_sel` = 5, `ex_dest` = 0, and every 1-bit output = 0.
  - Forward inputs still affect `alu_a`/`alu_b` only if registered rs/rt ≠ 0; after reset they are 0, so the outputs stay 0.
- **Priority per edge:** `rst` > `flush` > `stall` > normal load. Flush with stall asserted loads a bubble.
- **Stall:** all registers hold, but forwarding remains live. Held operands therefore track newly arriving EX/MEM and MEM/WB values.
- **Reset mid-stall or mid-flush:** reset wins immediately; the first post-reset edge with no stall/flush loads the ID inputs.

## Structure
- **Shared package `mips_pkg`:**
  - opcode and funct localparams;
  - ALU select constants (matching the codes above);
  - extension-type enum (SIGN, ZERO).
- **Sub-module `alu_decode`:** combinational; maps opcode/funct to sel, b_is_imm, ext type, dest select, we, class flags and illegal.
- **Top level:** pipeline registers plus two forwarding muxes.

## Test plan
- **Reset:** assert `rst` mid-cycle with a valid instruction loaded → all outputs read zeros immediately, `alu_sel` = 5.
- **ADD and SLTI:** issue `add` rd=3, rs=1 (5), rt=2 (7); then `slti` rs=1, imm=0xFFFF.
  - `add`: next cycle `alu_a` = 5, `alu_b` = 7, `alu_sel` = 5, `ex_dest` = 3, `ex_dest_we` = 1.
  - `slti`: `alu_b` = 0xFFFFFFFF, `alu_sel` = 8.
- **ORI zero-extension:** `ori` imm=0x8000 → `alu_b` = 0x00008000, `alu_sel` = 3.
- **Forward priority:** registered rs = 4; `exmem` (we=1, rd=4, 0xAA) and `memwb` (we=1, rd=4, 0xBB).
  - `alu_a` = 0xAA.
  - Drop exmem_we → `alu_a` = 0xBB.
  - Set rs = 0 with rd = 0 → no forward.
- **Stall/flush:** stall for 3 cycles while ID inputs change → EX fields unchanged and forwarding still tracks. Assert flush+stall → `ex_valid` = 0, `ex_dest_we` = 0 next cycle.
- **Branch/store/illegal:**
  - `beq` → `alu_sel` = 6, `ex_is_beq` = 1, we = 0.
  - `sw` → `store_data` = forwarded rt.
  - opcode 0x3F → `ex_illegal` = 1, we = 0.
